// File: rtl/datapath_pipe_if.sv
// datapath_pipe_if: beat-in / result-out handshake bundle for datapath_pipe.
// The slave modport is the datapath side, the master modport is the producer/consumer side.
interface datapath_pipe_if #(
   parameter int unsigned LANES     = 64,
   parameter int unsigned IPREC     = 8,
   parameter int unsigned OPREC     = 32,
   parameter int unsigned MEM_DEPTH = 512
);
   localparam int unsigned DATAW = LANES * IPREC;
   localparam int unsigned ADDRW = $clog2(MEM_DEPTH);

   logic             i_valid;
   logic             o_ready;
   logic [DATAW-1:0] i_dataa;
   logic [DATAW-1:0] i_datab;
   logic [IPREC-1:0] i_datac;
   logic [ADDRW-1:0] i_accum_addr;
   logic             i_accum;
   logic             i_last;
   logic             i_reduce;
   logic             i_signed;
   logic             o_valid;
   logic             i_ready;
   logic [OPREC-1:0] o_result;

   modport slave (
      input  i_valid, i_dataa, i_datab, i_datac, i_accum_addr, i_accum, i_last, i_reduce,
      input  i_signed, i_ready,
      output o_ready, o_valid, o_result
   );

   modport master (
      output i_valid, i_dataa, i_datab, i_datac, i_accum_addr, i_accum, i_last, i_reduce,
      output i_signed, i_ready,
      input  o_ready, o_valid, o_result
   );
endinterface

// File: rtl/datapath_pipe.sv
// datapath_pipe: pipelined LANES-wide dot product, per-address accumulator memory and a
// credit-controlled output FIFO. Define DATAPATH_SAT_EN for saturating accumulate/emit adders.
module datapath_pipe #(
   parameter int unsigned LANES      = 64,
   parameter int unsigned IPREC      = 8,
   parameter int unsigned OPREC      = 32,
   parameter int unsigned MEM_DEPTH  = 512,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic            clk,
   input logic            rst,
   datapath_pipe_if.slave bus
);
   localparam int unsigned DATAW = LANES * IPREC;
   localparam int unsigned ADDRW = $clog2(MEM_DEPTH);
   localparam int unsigned LVLS  = $clog2(LANES);
   localparam int unsigned PW    = 2 * IPREC + 1;
   localparam int unsigned DW    = PW + LVLS;
   localparam int unsigned SW    = ((OPREC > DW) ? OPREC : DW) + 2;
   localparam int unsigned NST   = LVLS + 3;
   localparam int unsigned FAW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic             valid;
      logic [ADDRW-1:0] addr;
      logic             accum;
      logic             last;
      logic             reduce;
      logic             sgn;
      logic [IPREC-1:0] bias;
   } side_t;

   // Reduce a wide sum to OPREC bits: clamp when saturating, otherwise wrap.
   function automatic logic [OPREC-1:0] clip(input logic [SW-1:0] v);
`ifdef DATAPATH_SAT_EN
      if (v[SW-1:OPREC-1] == {(SW-OPREC+1){v[SW-1]}}) return v[OPREC-1:0];
      return v[SW-1] ? {1'b1, {(OPREC-1){1'b0}}} : {1'b0, {(OPREC-1){1'b1}}};
`else
      return v[OPREC-1:0];
`endif
   endfunction

   side_t            side_q [NST];
   side_t            side_d [NST];
   logic [DATAW-1:0] a_q, a_d, b_q, b_d;
   logic [DW-1:0]    tree_q [1:2*LANES-1];
   logic [DW-1:0]    tree_d [1:2*LANES-1];
   logic [OPREC-1:0] mem_q  [MEM_DEPTH];
   logic [OPREC-1:0] rd_q, rd_d;
   logic [OPREC-1:0] acc_q, acc_d;
   logic [OPREC-1:0] fifo_q [FIFO_DEPTH];
   logic [FAW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cred_q, cred_d;

   side_t            rs, acs, ems;
   logic             ready, accept, push, pop, empty;
   logic [SW-1:0]    acc_sum, emit_sum, bias_x;
   logic [OPREC-1:0] acc_new, result;

   assign rs  = side_q[LVLS];
   assign acs = side_q[LVLS+1];
   assign ems = side_q[LVLS+2];

   // Input capture and sideband shift alongside the product/tree stages
   always_comb begin
      ready  = (cred_q < CW'(FIFO_DEPTH));
      accept = bus.i_valid & ready;
      a_d    = accept ? bus.i_dataa : a_q;
      b_d    = accept ? bus.i_datab : b_q;
      side_d[0] = '{valid: accept, addr: bus.i_accum_addr, accum: bus.i_accum,
                    last: bus.i_last, reduce: bus.i_reduce, sgn: bus.i_signed,
                    bias: bus.i_datac};
      for (int s = 1; s < NST; s++) side_d[s] = side_q[s-1];
   end

   // Heap-ordered tree: leaves LANES..2*LANES-1 hold products, node k sums 2k and 2k+1.
   always_comb begin
      logic [PW-1:0] ea, eb, prod;
      ea   = '0;
      eb   = '0;
      prod = '0;
      for (int k = 1; k < LANES; k++) tree_d[k] = tree_q[2*k] + tree_q[2*k+1];
      for (int k = 0; k < LANES; k++) begin
         ea   = {{(PW-IPREC){side_q[0].sgn & a_q[k*IPREC+IPREC-1]}}, a_q[k*IPREC +: IPREC]};
         eb   = {{(PW-IPREC){side_q[0].sgn & b_q[k*IPREC+IPREC-1]}}, b_q[k*IPREC +: IPREC]};
         prod = ea * eb;
         tree_d[LANES+k] = {{(DW-PW){prod[PW-1]}}, prod};
      end
   end

   // Synchronous read one stage ahead; a write landing on the same edge is forwarded.
   always_comb begin
      acc_sum = (acs.accum ? {{(SW-OPREC){rd_q[OPREC-1]}}, rd_q} : '0)
              + {{(SW-DW){tree_q[1][DW-1]}}, tree_q[1]};
      acc_new = clip(acc_sum);
      acc_d   = acc_new;
      rd_d    = (acs.valid && (acs.addr == rs.addr)) ? acc_new : mem_q[rs.addr];
   end

   always_comb begin
      bias_x   = {{(SW-IPREC){ems.sgn & ems.bias[IPREC-1]}}, ems.bias};
      emit_sum = {{(SW-OPREC){acc_q[OPREC-1]}}, acc_q} + (ems.reduce ? bias_x : '0);
      result   = clip(emit_sum);
      push     = ems.valid & ems.last;
      empty    = (wptr_q == rptr_q);
      pop      = ~empty & bus.i_ready;
      wptr_d   = wptr_q + {{FAW{1'b0}}, push};
      rptr_d   = rptr_q + {{FAW{1'b0}}, pop};
      cred_d   = cred_q;
      unique case ({accept & bus.i_last, pop})
         2'b10:   cred_d = cred_q + 1'b1;
         2'b01:   cred_d = cred_q - 1'b1;
         default: cred_d = cred_q;
      endcase
      bus.o_ready  = ready;
      bus.o_valid  = ~empty;
      bus.o_result = empty ? '0 : fifo_q[rptr_q[FAW-1:0]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         side_q <= '{default: '0};
         wptr_q <= '0;
         rptr_q <= '0;
         cred_q <= '0;
      end else begin
         side_q <= side_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cred_q <= cred_d;
      end
   end

   // Datapath storage carries no reset; qualifying valid bits are reset above.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      tree_q <= tree_d;
      rd_q   <= rd_d;
      acc_q  <= acc_d;
      if (acs.valid) mem_q[acs.addr] <= acc_new;
      if (push) fifo_q[wptr_q[FAW-1:0]] <= result;
   end
endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed beats with a scoreboard queue checked by independent monitors.
// A second instance with OPREC=16 covers wrap/saturation on an oversize dot product.
module tb_datapath_pipe;
   localparam int unsigned LANES      = 64;
   localparam int unsigned IPREC      = 8;
   localparam int unsigned OPREC      = 32;
   localparam int unsigned MEM_DEPTH  = 512;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned ADDRW      = $clog2(MEM_DEPTH);
   localparam int unsigned LAT        = 3 + $clog2(LANES);

   typedef struct {
      logic [OPREC-1:0] res;
      bit               lat_chk;
      int unsigned      acc_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   int          n_out = 0;
   exp_t        sb[$];
   logic [15:0] sb16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   datapath_pipe_if #(.LANES(LANES), .IPREC(IPREC), .OPREC(OPREC), .MEM_DEPTH(MEM_DEPTH)) bus ();
   datapath_pipe_if #(.LANES(LANES), .IPREC(IPREC), .OPREC(16), .MEM_DEPTH(MEM_DEPTH)) bus16 ();

   datapath_pipe #(.LANES(LANES), .IPREC(IPREC), .OPREC(OPREC), .MEM_DEPTH(MEM_DEPTH),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   datapath_pipe #(.LANES(LANES), .IPREC(IPREC), .OPREC(16), .MEM_DEPTH(MEM_DEPTH),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Present one beat from a negedge; returns at the negedge after it is accepted.
   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input int addr, input bit accum, input bit last, input bit reduce,
                       input bit sgn, input bit push, input logic [31:0] exp, input bit lat);
      int t = 0;
      bus.i_valid      = 1'b1;
      bus.i_dataa      = {LANES{a}};
      bus.i_datab      = {LANES{b}};
      bus.i_datac      = c;
      bus.i_accum_addr = ADDRW'(addr);
      bus.i_accum      = accum;
      bus.i_last       = last;
      bus.i_reduce     = reduce;
      bus.i_signed     = sgn;
      while (!bus.o_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.o_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: o_ready got 0, expected 1 within 200 cycles");
         bus.i_valid = 1'b0;
      end else begin
         if (push) sb.push_back('{res: exp, lat_chk: lat, acc_cyc: cyc + 1});
         @(negedge clk);
         n_acc++;
      end
   endtask

   task automatic idle(input int n);
      bus.i_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (rst && bus.o_valid && bus.i_ready) begin
         n_out++;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, expected no output", bus.o_result);
         end else begin
            e = sb.pop_front();
            check("result", 64'(bus.o_result), 64'(e.res));
            if (e.lat_chk) check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
         end
      end
   end

   always @(negedge clk) begin
      logic [15:0] e16;
      #1;
      if (rst && bus16.o_valid && bus16.i_ready) begin
         if (sb16.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output16: got 0x%0h, expected no output", bus16.o_result);
         end else begin
            e16 = sb16.pop_front();
            check("oprec16_result", 64'(bus16.o_result), 64'(e16));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      int out_snap;
      bus.i_valid = 1'b0;    bus.i_dataa = '0;  bus.i_datab = '0;   bus.i_datac = '0;
      bus.i_accum_addr = '0; bus.i_accum = 1'b0; bus.i_last = 1'b0; bus.i_reduce = 1'b0;
      bus.i_signed = 1'b0;   bus.i_ready = 1'b1;
      bus16.i_valid = 1'b0;  bus16.i_dataa = {LANES{8'hFF}}; bus16.i_datab = {LANES{8'hFF}};
      bus16.i_datac = '0;    bus16.i_accum_addr = '0; bus16.i_accum = 1'b0;
      bus16.i_last = 1'b1;   bus16.i_reduce = 1'b0; bus16.i_signed = 1'b0; bus16.i_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_o_ready", 64'(bus.o_ready), 64'd1);
      check("rst_o_result", 64'(bus.o_result), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // OPREC=16: 64 * 255 * 255 = 0x3F8040 overflows 16 bits
      bus16.i_valid = 1'b1;
`ifdef DATAPATH_SAT_EN
      sb16.push_back(16'h7FFF);
`else
      sb16.push_back(16'h8040);
`endif
      @(negedge clk);
      bus16.i_valid = 1'b0;

      // Two-beat accumulate with bias: 64 + 64 + 5, plus latency
      beat(8'd1, 8'd1, 8'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat(8'd1, 8'd1, 8'd5, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd133, 1'b1);
      idle(15);

      // Signed vs unsigned interpretation of 8'hFF
      beat(8'hFF, 8'd1, 8'd0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFC0, 1'b0);
      beat(8'hFF, 8'd1, 8'd0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd16320, 1'b0);
      idle(15);

      // Back-to-back same address exercises forwarding
      beat(8'd1, 8'd1, 8'd0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat(8'd1, 8'd1, 8'd0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat(8'd1, 8'd1, 8'd0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat(8'd1, 8'd1, 8'd0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd256, 1'b0);
      idle(15);

      // Backpressure: only FIFO_DEPTH results may be outstanding
      bus.i_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            for (int k = 0; k < 10; k++)
               beat(8'd1, 8'd1, 8'(k), k, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'(64 + k), 1'b0);
         end
         begin
            t = 0;
            while (n_acc < 8 && t < 300) begin
               @(negedge clk);
               t++;
            end
            repeat (4) @(negedge clk);
            check("bp_accepts", 64'(n_acc), 64'd8);
            check("bp_o_ready", 64'(bus.o_ready), 64'd0);
            check("bp_o_valid", 64'(bus.o_valid), 64'd1);
            check("bp_o_result_held", 64'(bus.o_result), 64'd64);
            bus.i_ready = 1'b1;
         end
      join
      idle(30);

      // Reset with beats in flight discards them
      beat(8'd1, 8'd1, 8'd0, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat(8'd1, 8'd1, 8'd0, 21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat(8'd1, 8'd1, 8'd0, 22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      bus.i_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_o_ready", 64'(bus.o_ready), 64'd1);
      check("post_rst_o_valid", 64'(bus.o_valid), 64'd0);
      out_snap = n_out;
      @(negedge clk);
      idle(20);
      check("post_rst_no_output", 64'(n_out), 64'(out_snap));
      // 3 * 2 * 64 = 384, signed bias -2
      beat(8'd3, 8'd2, 8'hFE, 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd382, 1'b0);
      idle(20);

      t = 0;
      while ((sb.size() != 0 || sb16.size() != 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0 || sb16.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: got %0d results pending, expected 0", sb.size() + sb16.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised, pipelined successor to the MVM lane datapath. It computes an IPREC-bit, LANES-wide dot product per accepted beat and accumulates it into an on-chip accumulator memory addressed per beat. Results are emitted through an output FIFO with full valid/ready backpressure. Each beat selects signed or unsigned operands, and a bias is optionally added on the final beat. It sits between the tile's operand buffers and the result write-back path.

## Interface
- LANES, 64, number of multiply lanes (power of two, ≥2)
- IPREC, 8, operand precision per lane
- OPREC, 32, accumulator/result precision
- DATAW, LANES*IPREC, operand bus width (derived, do not override)
- MEM_DEPTH, 512, accumulator memory entries
- ADDRW, $clog2(MEM_DEPTH), accumulator address width (derived)
- FIFO_DEPTH, 8, output FIFO entries (power of two)
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_dataa, i_datab  in  DATAW  lane operands; lane k = bits [k*IPREC +: IPREC]
- i_datac  in  IPREC  bias, interpreted per i_signed
- i_accum_addr  in  ADDRW  accumulator entry
- i_accum  in  1  1: add to stored value; 0: overwrite
- i_last  in  1  emit a result for this beat
- i_reduce  in  1  add bias to the emitted result (only with i_last)
- i_signed  in  1  1: operands and bias are two's complement; 0: unsigned
- o_valid  out  1  result available
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_result  out  OPREC  result, two's complement

## Operation
- Products: per lane, IPREC×IPREC, extended to 2*IPREC+1 signed bits per i_signed.
- Reduction: a registered binary adder tree with $clog2(LANES) levels and full-precision growth.
- Accumulate: acc_new = (i_accum ? mem[addr] : 0) + dot, computed at OPREC bits.
  - mem[addr] ← acc_new on every accepted beat.
- Hazard forwarding: the stored value used is always the most recent write to that address, including a write in the immediately preceding cycle. Back-to-back beats to the same address must accumulate correctly.
- Emit: if i_last, result = acc_new + (i_reduce ? ext(i_datac) : 0). The result is pushed to the FIFO. The bias is never written back to memory.
- Beats with i_last=0 produce no output.
- Credit counter: tracks in-flight i_last beats plus FIFO occupancy, range 0..FIFO_DEPTH.
  - o_ready = (credits < FIFO_DEPTH).
  - Accept with i_last → +1; FIFO pop → −1; simultaneous accept and pop → unchanged.
  - The FIFO never overflows.
- Output order equals acceptance order.
- Accumulator memory is not reset. The first beat to any address after reset must use i_accum=0; otherwise the result is undefined.

## Timing
- Latency LAT = 3 + $clog2(LANES) edges: 9 for LANES=64.
  - Edge 0 samples the beat.
  - Edge 1 registers products.
  - Edges 2..1+log2 are the tree levels.
  - The next edge performs accumulate/write.
  - The final edge writes the FIFO.
- o_valid rises in the cycle after edge LAT when the FIFO was empty.
- Throughput: one beat per cycle while o_ready=1.
- o_valid/o_result are held stable until popped.
- Reset values: o_valid=0, o_ready=1, o_result=0, credits=0, FIFO empty, all pipeline valid bits 0.
- Reset mid-operation: in-flight beats and FIFO contents are discarded. o_ready is 1 in the first cycle after release.
- FIFO full with i_ready=1: a pop and an internal push in the same cycle are both honoured.

## Configuration
- DATAPATH_SAT_EN defined: the accumulate and emit adders saturate to [−2^(OPREC−1), 2^(OPREC−1)−1]. The saturated value is stored and emitted.
- Undefined: both adders wrap modulo 2^OPREC.

## Test plan
- Unsigned all-ones, two beats: beat 1 addr 0, i_accum=0, i_last=0; beat 2 addr 0, i_accum=1, i_last=1, i_reduce=1, i_datac=5 → single o_result=133, o_valid exactly LAT+1 cycles after beat 2.
- Signed, i_dataa all 8'hFF, i_datab all 8'd1, i_last=1, i_reduce=0 → o_result=32'hFFFFFFC0 (−64). The same operands with i_signed=0 → 16320.
- Back-to-back same address: 4 consecutive beats to addr 7, all-ones, i_accum=0,1,1,1, last on beat 4 → 256 (forwarding).
- Backpressure: i_ready=0, 10 consecutive i_last beats with addresses 0..9 and i_datac=k, i_reduce=1 → o_ready drops after 8 accepts. After i_ready=1, results 64+k are emitted in order and none are lost.
- OPREC=16, all lanes 8'hFF unsigned, i_last=1 → 32767 with DATAPATH_SAT_EN, 16'h8040 without.
- Reset asserted while 3 beats are in flight → no o_valid after release. A new beat then yields its correct result.
